// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_tx
// Description : Parallel-to-serial word transmitter. A WIDTH-bit word is
//               captured through a valid/ready load handshake and shifted out
//               one bit per accepted cycle on a valid/ready serial link, with
//               first-bit (sof) and last-bit (eof) framing strobes.
//
// Ports       : clk           rising-edge clock
//               rst_n         asynchronous reset, active low
//               din_i         parallel word to send
//               load_valid_i  din_i is valid
//               load_ready_o  block can accept din_i this cycle
//               sout_o        serial data bit
//               sout_valid_o  sout_o carries a live bit
//               sout_ready_i  receiver consumes the current bit this cycle
//               sof_o         sout_o is the first transmitted bit of a word
//               eof_o         sout_o is the last transmitted bit of a word
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_tx #(
    parameter int WIDTH     = 8,     // word length, 2..32
    parameter bit MSB_FIRST = 1'b0   // 0: LSB first, 1: MSB first
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    input  logic             sout_ready_i,
    output logic             sof_o,
    output logic             eof_o
);

    localparam int              c_CW    = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);

    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [c_CW-1:0]  cnt_q,   cnt_d;

    logic             w_shift;
    logic             w_eof;
    logic             w_consume;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    assign w_shift      = (state_q == c_SHIFT);
    assign w_eof        = w_shift & (cnt_q == c_LAST);
    assign w_consume    = w_shift & sout_ready_i;
    // Ready again while the last bit is being consumed, so a following word
    // can be loaded with no idle gap on the serial link.
    assign w_load_ready = ~w_shift | (w_eof & sout_ready_i);
    assign w_accept     = load_valid_i & w_load_ready;

    // The bit on the wire is always the head of the shift register; each
    // consumed bit shifts the next one into the head position.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head    = shreg_q[WIDTH-1];
            assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head    = shreg_q[0];
            assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (w_accept) begin
            // Covers both a load from IDLE and a chained load on the last bit.
            state_d = c_SHIFT;
            shreg_d = din_i;
            cnt_d   = '0;
        end else if (w_consume) begin
            shreg_d = w_shifted;
            if (w_eof) begin
                state_d = c_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // All serial outputs decode registered state only and are gated by SHIFT,
    // so they drop immediately on reset and are quiet in IDLE.
    assign load_ready_o = w_load_ready;
    assign sout_valid_o = w_shift;
    assign sout_o       = w_shift & w_head;
    assign sof_o        = w_shift & (cnt_q == '0);
    assign eof_o        = w_eof;

endmodule
`default_nettype wire
